// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: sequencer states, opcode map, fault codes and
// opcode class helpers used by the phase sequencer, base decoder and benches.
package mu0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC1,
        ST_EXEC2,
        ST_EXT_WAIT,
        ST_HALTED,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STO = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JGE = 4'b0101;
    localparam logic [3:0] OP_JNE = 4'b0110;
    localparam logic [3:0] OP_STP = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_ORR = 4'b1001;
    localparam logic [3:0] OP_EOR = 4'b1010;
    localparam logic [3:0] OP_RSV = 4'b1011;
    localparam logic [3:0] OP_FBC = 4'b1100;
    localparam logic [3:0] OP_RND = 4'b1101;
    localparam logic [3:0] OP_LNK = 4'b1110;
    localparam logic [3:0] OP_BAD = 4'b1111;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    // Instructions that need a second execute phase (memory operand).
    function automatic logic is_extra(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Instructions handed off to an extension unit with a done handshake.
    function automatic logic is_ext(input logic [3:0] op);
        return (op == OP_FBC) || (op == OP_RND) || (op == OP_LNK);
    endfunction

    // Unassigned encodings that trap.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_RSV) || (op == OP_BAD);
    endfunction

    function automatic logic is_stp(input logic [3:0] op);
        return op == OP_STP;
    endfunction

    // Single execute phase instructions.
    function automatic logic is_simple(input logic [3:0] op);
        return op inside {OP_STO, OP_JMP, OP_JGE, OP_JNE, OP_AND, OP_ORR, OP_EOR};
    endfunction

endpackage

// File: rtl/mu0_ext_timer.sv
// Extension handshake timer: counts wait cycles and flags the final
// permitted cycle so the sequencer can trap a stuck extension unit.
module mu0_ext_timer #(
    parameter int LIMIT = 16,
    parameter int TO_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    output logic [TO_W-1:0] count,
    output logic            expired
);

    // Count wait cycles; held at zero whenever no wait is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = (count == TO_W'(LIMIT - 1));

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 phase sequencer: generates one-hot Fetch/Exec1/Exec2 strobes, the
// extension unit handshake, halt/fault status and a retired-instruction count.
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int EXT_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic             ext_done,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             ext_start,
    output logic             ext_busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);

    state_t          state;
    state_t          state_nxt;
    state_t          after_retire;
    logic            retire;
    logic            fc_load;
    logic [1:0]      fc_value;
    logic [TO_W-1:0] to_count;
    logic            to_expired;

    mu0_ext_timer #(
        .LIMIT (EXT_TIMEOUT),
        .TO_W  (TO_W)
    ) u_ext_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ST_EXT_WAIT),
        .enable  ((state == ST_EXT_WAIT) && !ext_done),
        .count   (to_count),
        .expired (to_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state selection plus retire and fault-capture strobes.
    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        fc_load      = 1'b0;
        fc_value     = FC_NONE;
        after_retire = (step_mode || !run) ? ST_IDLE : ST_FETCH;
        case (state)
            ST_IDLE: begin
                if (run && (!step_mode || step))
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                state_nxt = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (is_extra(op)) begin
                    state_nxt = ST_EXEC2;
                end else if (is_stp(op)) begin
                    retire    = 1'b1;
                    state_nxt = ST_HALTED;
                end else if (is_ext(op)) begin
                    state_nxt = ST_EXT_WAIT;
                end else if (is_illegal(op)) begin
                    fc_load   = 1'b1;
                    fc_value  = FC_ILLEGAL;
                    state_nxt = ST_FAULT;
                end else begin
                    retire    = 1'b1;
                    state_nxt = after_retire;
                end
            end
            ST_EXEC2: begin
                retire    = 1'b1;
                state_nxt = after_retire;
            end
            ST_EXT_WAIT: begin
                if (ext_done) begin
                    retire    = 1'b1;
                    state_nxt = after_retire;
                end else if (to_expired) begin
                    fc_load   = 1'b1;
                    fc_value  = FC_TIMEOUT;
                    state_nxt = ST_FAULT;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // Retired-instruction counter and sticky fault code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            fault_code  <= FC_NONE;
        end else begin
            if (retire)
                instr_count <= instr_count + 1'b1;
            if (fc_load)
                fault_code <= fc_value;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        fetch     = 1'b0;
        exec1     = 1'b0;
        exec2     = 1'b0;
        ext_start = 1'b0;
        ext_busy  = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_FETCH:    fetch  = 1'b1;
            ST_EXEC1:    exec1  = 1'b1;
            ST_EXEC2:    exec2  = 1'b1;
            ST_EXT_WAIT: begin
                ext_busy  = 1'b1;
                ext_start = (to_count == '0);
            end
            ST_HALTED:   halted = 1'b1;
            ST_FAULT:    fault  = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// Directed bench for mu0_phase_sequencer: a cycle model pushes expected
// outputs to a scoreboard queue, popped and compared after each clock edge.
module tb_mu0_phase_sequencer;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n, run, step_mode, step, ext_done;
    logic [3:0]  op;

    logic        fetch, exec1, exec2, ext_start, ext_busy, halted, fault;
    logic [1:0]  fault_code;
    logic [15:0] instr_count;

    logic        fetch2, exec1_2, exec2_2, ext_start2, ext_busy2, halted2, fault2;
    logic [1:0]  fault_code2;
    logic [3:0]  instr_count2;

    typedef struct packed {
        logic        fetch;
        logic        exec1;
        logic        exec2;
        logic        ext_start;
        logic        ext_busy;
        logic        halted;
        logic        fault;
        logic [1:0]  fault_code;
        logic [15:0] count;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   start_seen  = 0;
    int   busy_seen   = 0;

    // Reference model: 0 idle, 1 fetch, 2 exec1, 3 exec2, 4 wait, 5 halted, 6 fault
    int   m_state, m_to, m_cnt, m_fc;

    mu0_phase_sequencer dut (
        .clk (clk), .rst_n (rst_n), .run (run), .step_mode (step_mode),
        .step (step), .op (op), .ext_done (ext_done),
        .fetch (fetch), .exec1 (exec1), .exec2 (exec2),
        .ext_start (ext_start), .ext_busy (ext_busy), .halted (halted),
        .fault (fault), .fault_code (fault_code), .instr_count (instr_count)
    );

    mu0_phase_sequencer #(.CNT_W (4)) dut_narrow (
        .clk (clk), .rst_n (rst_n), .run (run), .step_mode (step_mode),
        .step (step), .op (op), .ext_done (ext_done),
        .fetch (fetch2), .exec1 (exec1_2), .exec2 (exec2_2),
        .ext_start (ext_start2), .ext_busy (ext_busy2), .halted (halted2),
        .fault (fault2), .fault_code (fault_code2), .instr_count (instr_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t dut_obs();
        obs_t o;
        o = {fetch, exec1, exec2, ext_start, ext_busy, halted, fault, fault_code, instr_count};
        return o;
    endfunction

    function automatic obs_t dut2_obs();
        obs_t o;
        o = {fetch2, exec1_2, exec2_2, ext_start2, ext_busy2, halted2, fault2, fault_code2,
             12'h000, instr_count2};
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        case (m_state)
            1: o.fetch = 1'b1;
            2: o.exec1 = 1'b1;
            3: o.exec2 = 1'b1;
            4: begin
                o.ext_busy  = 1'b1;
                o.ext_start = (m_to == 0);
            end
            5: o.halted = 1'b1;
            6: o.fault  = 1'b1;
            default: ;
        endcase
        o.fault_code = m_fc[1:0];
        o.count      = m_cnt[15:0];
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_to    = 0;
        m_cnt   = 0;
        m_fc    = 0;
    endtask

    task automatic model_edge();
        int after;
        after = (step_mode || !run) ? 0 : 1;
        case (m_state)
            0: if (run && (!step_mode || step)) m_state = 1;
            1: m_state = 2;
            2: case (op)
                4'h0, 4'h2, 4'h3: m_state = 3;
                4'h7: begin m_cnt++; m_state = 5; end
                4'hC, 4'hD, 4'hE: begin m_to = 0; m_state = 4; end
                4'hB, 4'hF: begin m_fc = 1; m_state = 6; end
                default: begin m_cnt++; m_state = after; end
            endcase
            3: begin m_cnt++; m_state = after; end
            4: begin
                if (ext_done) begin
                    m_cnt++;
                    m_state = after;
                end else if (m_to == TB_TIMEOUT - 1) begin
                    m_fc    = 2;
                    m_state = 6;
                end else begin
                    m_to++;
                end
            end
            default: ;
        endcase
        m_cnt = m_cnt & 32'hFFFF;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, scoring both DUTs against the model each cycle.
    task automatic apply_stimulus(input int n);
        obs_t e;
        obs_t e2;
        for (int i = 0; i < n; i++) begin
            model_edge();
            exp_q.push_back(model_obs());
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            e2 = e;
            e2.count = e.count & 16'h000F;
            check_output("cycle_vector", 32'(dut_obs()), 32'(e));
            check_output("cycle_vector_narrow", 32'(dut2_obs()), 32'(e2));
            start_seen += int'(ext_start);
            busy_seen  += int'(ext_busy);
        end
    endtask

    // Assert reset between clock edges, check outputs clear at once, release.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        exp_q.delete();
        check_output("reset_outputs", 32'(dut_obs()), 32'h0);
        check_output("reset_outputs_narrow", 32'(dut2_obs()), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; step_mode = 1'b0; step = 1'b0;
        op = 4'h1; ext_done = 1'b0;
        model_reset();

        $display("[TB] simple instruction stream");
        pulse_reset();
        apply_stimulus(1);
        check_output("first_fetch", 32'(fetch), 32'd1);
        apply_stimulus(10);
        check_output("simple_count", 32'(instr_count), 32'd5);

        $display("[TB] ADD stream then STP");
        op = 4'h2;
        apply_stimulus(6);
        check_output("add_count", 32'(instr_count), 32'd7);
        op = 4'h7;
        apply_stimulus(2);
        check_output("halted_set", 32'(halted), 32'd1);
        apply_stimulus(20);
        check_output("halted_count", 32'(instr_count), 32'd8);

        $display("[TB] extension handshake and timeout");
        op = 4'hD;
        pulse_reset();
        apply_stimulus(2);
        start_seen = 0;
        busy_seen  = 0;
        apply_stimulus(4);
        ext_done = 1'b1;
        apply_stimulus(1);
        ext_done = 1'b0;
        check_output("ext_start_cycles", 32'(start_seen), 32'd1);
        check_output("ext_busy_cycles", 32'(busy_seen), 32'd4);
        check_output("ext_then_fetch", 32'(fetch), 32'd1);
        check_output("ext_count", 32'(instr_count), 32'd1);
        apply_stimulus(1);
        busy_seen = 0;
        apply_stimulus(17);
        check_output("timeout_busy_cycles", 32'(busy_seen), 32'd16);
        check_output("timeout_fault", 32'(fault), 32'd1);
        check_output("timeout_code", 32'(fault_code), 32'd2);
        apply_stimulus(5);
        check_output("timeout_count", 32'(instr_count), 32'd1);

        $display("[TB] illegal opcode");
        op = 4'hF;
        pulse_reset();
        apply_stimulus(2);
        check_output("illegal_exec1", 32'(exec1), 32'd1);
        start_seen = 0;
        apply_stimulus(1);
        check_output("illegal_fault", 32'(fault), 32'd1);
        check_output("illegal_code", 32'(fault_code), 32'd1);
        check_output("illegal_no_start", 32'(start_seen), 32'd0);
        check_output("illegal_count", 32'(instr_count), 32'd0);

        $display("[TB] single-step mode");
        op = 4'h1;
        step_mode = 1'b1;
        pulse_reset();
        apply_stimulus(5);
        step = 1'b1;
        apply_stimulus(1);
        step = 1'b0;
        check_output("step_fetch", 32'(fetch), 32'd1);
        apply_stimulus(1);
        step = 1'b1;
        apply_stimulus(1);
        step = 1'b0;
        apply_stimulus(3);
        check_output("step_one_instr", 32'(instr_count), 32'd1);
        check_output("step_idle", 32'(fetch | exec1), 32'd0);
        step = 1'b1;
        apply_stimulus(1);
        step = 1'b0;
        apply_stimulus(3);
        check_output("step_two_instr", 32'(instr_count), 32'd2);

        $display("[TB] reset during extension wait, counter wrap");
        step_mode = 1'b0;
        op = 4'hC;
        pulse_reset();
        apply_stimulus(5);
        check_output("wait_busy", 32'(ext_busy), 32'd1);
        op = 4'h1;
        pulse_reset();
        apply_stimulus(1);
        check_output("post_reset_fetch", 32'(fetch), 32'd1);
        apply_stimulus(34);
        check_output("count_17", 32'(instr_count), 32'd17);
        check_output("narrow_wrap", 32'(instr_count2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
